// File: rtl/mem_io_cycle_fsm.sv
// mem_io_cycle_fsm: Z80 memory/IO read/write machine-cycle engine with wait states and read capture
module mem_io_cycle_fsm (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        start,
  input  logic        is_write,
  input  logic        is_io,
  input  logic [15:0] addr_in,
  input  logic [7:0]  wr_data,
  input  logic [7:0]  data_in,
  input  logic        WAIT_L,
  output logic [15:0] addr_out,
  output logic [7:0]  data_out,
  output logic        drive_addr,
  output logic        drive_data,
  output logic        MREQ_L,
  output logic        IORQ_L,
  output logic        RD_L,
  output logic        WR_L,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, T1, T2, TWA, TW, T3} state_t;
  state_t state, next;
  logic [15:0] a_q;
  logic [7:0] d_q;
  logic w_q, io_q, load;
  assign load = start && (state == IDLE || state == T3);
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? T1 : IDLE;
      T1:      next = T2;
      T2:      next = io_q ? TWA : (WAIT_L ? T3 : TW);
      TWA, TW: next = WAIT_L ? T3 : TW;
      T3:      next = start ? T1 : IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state    <= IDLE;
      a_q      <= '0;
      d_q      <= '0;
      w_q      <= 1'b0;
      io_q     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= next;
      rd_valid <= state == T3 && !w_q;
      if (state == T3 && !w_q) rd_data <= data_in;
      if (load) begin
        a_q  <= addr_in;
        d_q  <= wr_data;
        w_q  <= is_write;
        io_q <= is_io;
      end
    end
  end
  assign busy       = state != IDLE;
  assign done       = state == T3;
  assign drive_addr = busy;
  assign drive_data = busy && w_q;
  assign addr_out   = busy ? a_q : 16'h0000;
  assign data_out   = drive_data ? d_q : 8'h00;
  assign MREQ_L     = !(busy && !io_q);
  assign IORQ_L     = !(busy && io_q && state != T1);
  assign RD_L       = !(busy && !w_q && (!io_q || state != T1));
  assign WR_L       = !(busy && w_q && state != T1);
endmodule

// File: tb/tb_mem_io_cycle_fsm.sv
// tb_mem_io_cycle_fsm: transaction-level model check of the bus-cycle engine
module tb_mem_io_cycle_fsm;
  logic clk, rst_L, start, is_write, is_io, WAIT_L;
  logic [15:0] addr_in, addr_out;
  logic [7:0] wr_data, data_in, data_out, rd_data;
  logic drive_addr, drive_data, MREQ_L, IORQ_L, RD_L, WR_L, rd_valid, done, busy;
  int checks = 0, failures = 0;
  logic [7:0] exp_rd = 8'h00;
  bit exp_rv = 0;
  typedef struct {
    bit w; bit io; logic [15:0] a; logic [7:0] d; logic [7:0] din; int nw; bit b2b; int gap;
  } txn_t;
  txn_t q[$];

  mem_io_cycle_fsm dut (
    .clk(clk), .rst_L(rst_L), .start(start), .is_write(is_write), .is_io(is_io),
    .addr_in(addr_in), .wr_data(wr_data), .data_in(data_in), .WAIT_L(WAIT_L),
    .addr_out(addr_out), .data_out(data_out), .drive_addr(drive_addr), .drive_data(drive_data),
    .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic txn_t mk(bit w, bit io, logic [15:0] a, logic [7:0] d, logic [7:0] din, int nw, bit b2b, int gap);
    txn_t t;
    t.w = w; t.io = io; t.a = a; t.d = d; t.din = din; t.nw = nw; t.b2b = b2b; t.gap = gap;
    return t;
  endfunction

  // A cycle is T1, T2, [TWA for I/O], nw waits, T3; k indexes into that sequence.
  task automatic run_txns();
    txn_t c, n;
    bit act = 0, go;
    int k = 0, len = 0, idx = 0, idle_n = 0, guard = 0;
    logic [40:0] exp, got;
    c = mk(0, 0, 0, 0, 0, 0, 0, 0);
    while (guard < 5000 && !(idx >= q.size() && !act && idle_n >= 2)) begin
      guard++;
      @(negedge clk);
      len = 3 + int'(c.io) + c.nw;
      exp = act ? {1'b1, k == len - 1, 1'b1, c.w, c.io, !(c.io && k >= 1),
                   !(!c.w && (!c.io || k >= 1)), !(c.w && k >= 1), c.a, c.w ? c.d : 8'h00, exp_rv, exp_rd}
                : {4'b0000, 4'b1111, 16'h0000, 8'h00, exp_rv, exp_rd};
      got = {busy, done, drive_addr, drive_data, MREQ_L, IORQ_L, RD_L, WR_L, addr_out, data_out, rd_valid, rd_data};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL cycle txn=%0d k=%0d got=%h expected=%h", idx, k, got, exp);
      end
      start = 0; is_write = 1'($urandom); is_io = 1'($urandom); addr_in = 16'($urandom);
      wr_data = 8'($urandom); data_in = 8'($urandom); WAIT_L = 1'($urandom);
      go = 0;
      if (act) begin
        if (k >= 1 + int'(c.io) && k <= 1 + int'(c.io) + c.nw) WAIT_L = k < 1 + int'(c.io) + c.nw ? 1'b0 : 1'b1;
        if (k == len - 1) begin
          data_in = c.din;
          go = idx < q.size() && q[idx].b2b;
        end else start = 1'($urandom);
      end else go = idx < q.size() && idle_n >= q[idx].gap;
      if (go) begin
        n = q[idx]; start = 1; is_write = n.w; is_io = n.io; addr_in = n.a; wr_data = n.d;
      end
      @(posedge clk);
      exp_rv = act && k == len - 1 && !c.w;
      if (exp_rv) exp_rd = c.din;
      if (act && k < len - 1) k++;
      else if (go) begin c = n; act = 1; k = 0; idx++; idle_n = 0; end
      else begin idle_n = act ? 0 : idle_n + 1; act = 0; end
    end
    checks++;
    if (guard >= 5000) begin
      failures++;
      $display("FAIL run_timeout got=%0d required<%0d", guard, 5000);
    end
    q.delete();
    @(negedge clk);
    start = 0;
  endtask

  task automatic test_reset();
    rst_L = 0; start = 1; is_write = 1; is_io = 0; addr_in = 16'hFFFF; wr_data = 8'hFF; data_in = 8'hFF; WAIT_L = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, drive_addr, drive_data, MREQ_L, IORQ_L, RD_L, WR_L, addr_out, data_out, rd_valid, rd_data}
        !== {4'b0000, 4'b1111, 16'h0, 8'h0, 1'b0, 8'h0}) begin
      failures++;
      $display("FAIL reset_state busy=%b strobes=%b%b%b%b addr=%h data=%h rd=%h rv=%b", busy, MREQ_L, IORQ_L, RD_L, WR_L, addr_out, data_out, rd_data, rd_valid);
    end
    start = 0; rst_L = 1;
    exp_rd = 0; exp_rv = 0;
  endtask

  task automatic test_mem_read();
    q.push_back(mk(0, 0, 16'h1234, 8'h00, 8'hA5, 0, 0, 1));
    run_txns();
  endtask

  task automatic test_mem_write();
    q.push_back(mk(1, 0, 16'h8000, 8'h3C, 8'h99, 2, 0, 0));
    run_txns();
  endtask

  task automatic test_io_read();
    q.push_back(mk(0, 1, 16'h0012, 8'h00, 8'h7E, 0, 0, 0));
    q.push_back(mk(1, 1, 16'h00FE, 8'h5A, 8'h00, 1, 0, 1));
    run_txns();
  endtask

  task automatic test_back_to_back();
    q.push_back(mk(0, 0, 16'h0100, 8'h00, 8'h11, 0, 0, 0));
    q.push_back(mk(1, 0, 16'h0101, 8'h22, 8'h00, 0, 1, 0));
    q.push_back(mk(0, 1, 16'h0102, 8'h00, 8'h33, 0, 1, 0));
    q.push_back(mk(0, 0, 16'h0103, 8'h00, 8'h44, 1, 1, 0));
    run_txns();
  endtask

  task automatic test_reset_mid();
    int stuck;
    @(negedge clk);
    start = 1; is_write = 0; is_io = 0; addr_in = 16'h4444; WAIT_L = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    WAIT_L = 0;
    @(negedge clk);
    checks++;
    if (!busy || MREQ_L || RD_L || addr_out !== 16'h4444) begin
      failures++;
      $display("FAIL mid_wait_state busy=%b MREQ_L=%b RD_L=%b addr=%h required busy=1 strobes=0 addr=4444", busy, MREQ_L, RD_L, addr_out);
    end
    rst_L = 0;
    @(negedge clk);
    rst_L = 1;
    stuck = 0;
    repeat (4) begin
      checks++;
      if ({busy, done, drive_addr, drive_data, MREQ_L, IORQ_L, RD_L, WR_L, addr_out, data_out, rd_valid, rd_data}
          !== {4'b0000, 4'b1111, 16'h0, 8'h0, 1'b0, 8'h0}) begin
        failures++;
        $display("FAIL reset_mid busy=%b strobes=%b%b%b%b addr=%h rd=%h rv=%b required idle/1111/0000/00/0", busy, MREQ_L, IORQ_L, RD_L, WR_L, addr_out, rd_data, rd_valid);
      end
      @(negedge clk);
    end
    WAIT_L = 1;
    exp_rd = 0; exp_rv = 0;
  endtask

  task automatic test_random();
    repeat (40)
      q.push_back(mk(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                     $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 2)));
    run_txns();
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_mem_write();
    test_io_read();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
